// File: rtl/aq_ifu_ras_ctrl_if.sv
// Predict/commit request bus and entry-array connections of the IFU return address stack controller.
interface aq_ifu_ras_ctrl_if #(
   parameter int ENTRY_NUM = 4,
   parameter int PC_W      = 24
);
   logic                      pred_link_vld;
   logic [PC_W-1:0]           pred_link_pc;
   logic                      pred_ret_vld;
   logic                      iu_link_vld;
   logic                      iu_ret_vld;
   logic                      iu_pc_mispred;
   logic                      iu_bht_mispred;
   logic                      rtu_flush_fe;
   logic [ENTRY_NUM*PC_W-1:0] ras_entry_pc;
   logic                      ras_pred_rdy;
   logic [ENTRY_NUM-1:0]      ras_entry_upd;
   logic [PC_W-1:0]           ras_upd_pc;
   logic [PC_W-1:0]           ras_pred_tar_pc;
   logic                      ras_pred_tar_vld;
   logic                      ras_empty;
   logic                      ras_full;

   modport master (
      output pred_link_vld, pred_link_pc, pred_ret_vld,
      output iu_link_vld, iu_ret_vld, iu_pc_mispred, iu_bht_mispred, rtu_flush_fe,
      output ras_entry_pc,
      input  ras_pred_rdy, ras_entry_upd, ras_upd_pc, ras_pred_tar_pc,
      input  ras_pred_tar_vld, ras_empty, ras_full
   );

   modport slave (
      input  pred_link_vld, pred_link_pc, pred_ret_vld,
      input  iu_link_vld, iu_ret_vld, iu_pc_mispred, iu_bht_mispred, rtu_flush_fe,
      input  ras_entry_pc,
      output ras_pred_rdy, ras_entry_upd, ras_upd_pc, ras_pred_tar_pc,
      output ras_pred_tar_vld, ras_empty, ras_full
   );
endinterface

// File: rtl/aq_ifu_ras_ctrl.sv
// RAS pointer/occupancy controller: speculative and committed stacks, recovery, entry write/read steering.
// Optional statistics counters are built when AQ_IFU_RAS_STAT_EN is defined.
module aq_ifu_ras_ctrl #(
   parameter int ENTRY_NUM = 4,
   parameter int PTR_W     = 2,
   parameter int PC_W      = 24
) (
   input  logic                 ras_cpuclk,
   input  logic                 cpurst_b,
`ifdef AQ_IFU_RAS_STAT_EN
   output logic [15:0]          ras_stat_push,
   output logic [15:0]          ras_stat_pop,
   output logic [15:0]          ras_stat_undf,
   output logic [15:0]          ras_stat_rcvr,
`endif
   aq_ifu_ras_ctrl_if.slave     ras_if
);

   localparam logic [PTR_W:0]   CNT_MAX  = (PTR_W+1)'(ENTRY_NUM);
   localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(ENTRY_NUM-1);

   typedef enum logic [1:0] {INIT, RUN, RECOVER} state_t;

   typedef struct packed {
      logic [PTR_W-1:0] top;
      logic [PTR_W:0]   cnt;
   } stk_t;

   state_t state, state_nxt;
   stk_t   spec, spec_nxt, cmt, cmt_nxt;
   logic   recover;
   logic   pred_rdy;
   logic   spec_nonempty;

   // Pop-then-push on a non-empty stack replaces the top in place; a push when full drops the oldest.
   function automatic stk_t stk_upd(input stk_t cur, input logic push, input logic pop);
      stk_t nxt;
      nxt = cur;
      if (push && !(pop && cur.cnt != '0)) begin
         nxt.top = cur.top + PTR_W'(1);
         nxt.cnt = (cur.cnt == CNT_MAX) ? cur.cnt : cur.cnt + (PTR_W+1)'(1);
      end else if (!push && pop && cur.cnt != '0) begin
         nxt.top = cur.top - PTR_W'(1);
         nxt.cnt = cur.cnt - (PTR_W+1)'(1);
      end
      return nxt;
   endfunction

   assign recover = ras_if.rtu_flush_fe | ras_if.iu_bht_mispred |
                    (ras_if.iu_pc_mispred & ~ras_if.iu_link_vld);

   always_ff @(posedge ras_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) state <= INIT;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pred_rdy  = 1'b0;
      case (state)
         INIT:    state_nxt = RUN;
         RUN: begin
            pred_rdy = ~recover;
            if (recover) state_nxt = RECOVER;
         end
         RECOVER: state_nxt = recover ? RECOVER : RUN;
         default: state_nxt = INIT;
      endcase
   end

   assign cmt_nxt  = ras_if.rtu_flush_fe ? cmt
                                         : stk_upd(cmt, ras_if.iu_link_vld, ras_if.iu_ret_vld);
   assign spec_nxt = stk_upd(spec, ras_if.pred_link_vld, ras_if.pred_ret_vld);

   always_ff @(posedge ras_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) cmt <= '{top: PTR_INIT, cnt: '0};
      else           cmt <= cmt_nxt;
   end

   // Recovery wins over any predict request in the same cycle.
   always_ff @(posedge ras_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b)     spec <= '{top: PTR_INIT, cnt: '0};
      else if (recover)  spec <= cmt_nxt;
      else if (pred_rdy) spec <= spec_nxt;
   end

   assign spec_nonempty = (spec.cnt != '0);

   always_comb begin
      logic [PTR_W-1:0] wr_idx;
      wr_idx = (ras_if.pred_ret_vld && spec_nonempty) ? spec.top : spec.top + PTR_W'(1);
      ras_if.ras_entry_upd = '0;
      if (pred_rdy && ras_if.pred_link_vld)
         ras_if.ras_entry_upd = ENTRY_NUM'(1) << wr_idx;
   end

   assign ras_if.ras_pred_rdy     = pred_rdy;
   assign ras_if.ras_upd_pc       = ras_if.pred_link_pc;
   assign ras_if.ras_pred_tar_pc  = ras_if.ras_entry_pc[spec.top*PC_W +: PC_W];
   assign ras_if.ras_pred_tar_vld = spec_nonempty && (state == RUN);
   assign ras_if.ras_empty        = ~spec_nonempty;
   assign ras_if.ras_full         = (spec.cnt == CNT_MAX);

`ifdef AQ_IFU_RAS_STAT_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
      return (en && v != 16'hFFFF) ? v + 16'd1 : v;
   endfunction

   logic pred_pop_acc;
   assign pred_pop_acc = pred_rdy & ras_if.pred_ret_vld;

   always_ff @(posedge ras_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         ras_stat_push <= '0;
         ras_stat_pop  <= '0;
         ras_stat_undf <= '0;
         ras_stat_rcvr <= '0;
      end else begin
         ras_stat_push <= sat_inc(ras_stat_push, pred_rdy & ras_if.pred_link_vld);
         ras_stat_pop  <= sat_inc(ras_stat_pop,  pred_pop_acc & spec_nonempty);
         ras_stat_undf <= sat_inc(ras_stat_undf, pred_pop_acc & ~spec_nonempty);
         ras_stat_rcvr <= sat_inc(ras_stat_rcvr, (state == RUN) & recover);
      end
   end
`endif

endmodule
